// File: rtl/absorb_packer.sv
// absorb_packer: packs a valid/ready byte stream into 256-bit sponge-rate
// blocks, applies domain/0x80 padding to the final block and emits a pad-only
// block when the message ends exactly on a block boundary.
module absorb_packer #(
    parameter int         BYTES  = 32,
    parameter logic [7:0] DOMAIN = 8'h1F,
    parameter bit         PAD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [255:0] out_block,
    output logic [5:0]   out_length,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [5:0]   FULL_CNT  = 6'(BYTES);
    localparam logic [255:0] PAD_BLOCK = {DOMAIN, 240'h0, 8'h80};

    typedef enum logic [1:0] {
        FILL = 2'd0,
        OUT  = 2'd1,
        PAD  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [255:0]   buf_q, buf_d;
    logic           pend_pad_q, pend_pad_d;
    logic [5:0]     length_q, length_d;
    logic           last_q, last_d;

    logic           accept_s;
    logic [5:0]     cnt_inc_s;

    // Returns blk with byte slot idx (slot 0 = MSB byte) replaced by val;
    // an index of 32 or more leaves the block untouched.
    function automatic logic [255:0] put_byte(input logic [255:0] blk,
                                              input logic [5:0]   idx,
                                              input logic [7:0]   val);
        logic [255:0] res;
        res = blk;
        for (int i = 0; i < 32; i++) begin
            res[255 - 8*i -: 8] = (6'(i) == idx) ? val : res[255 - 8*i -: 8];
        end
        return res;
    endfunction

    assign accept_s  = in_valid && (state_q == FILL);
    assign cnt_inc_s = cnt_q + 6'd1;

    // Outputs are pure decodes of registered state; in_ready never sees out_ready.
    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q != FILL);
    assign out_block  = buf_q;
    assign out_length = length_q;
    assign out_last   = last_q;

    // Next-state logic: byte packing, end-of-message padding and handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        pend_pad_d = pend_pad_q;
        length_d   = length_q;
        last_d     = last_q;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    buf_d = put_byte(buf_q, cnt_q, in_data);
                    cnt_d = cnt_inc_s;
                    if (in_last) begin
                        state_d  = OUT;
                        length_d = cnt_inc_s;
                        if (cnt_inc_s == FULL_CNT) begin
                            // Full final block: padding moves to a block of its own.
                            last_d     = !PAD_EN;
                            pend_pad_d = PAD_EN;
                        end else begin
                            last_d = 1'b1;
                            if (PAD_EN) begin
                                // Remaining bytes are already zero; for n=31 the
                                // domain byte and 0x80 merge into one byte.
                                buf_d        = put_byte(buf_d, cnt_inc_s, DOMAIN);
                                buf_d[7:0]   = buf_d[7:0] | 8'h80;
                            end else begin
                                buf_d = buf_d;
                            end
                        end
                    end else if (cnt_inc_s == FULL_CNT) begin
                        state_d  = OUT;
                        length_d = FULL_CNT;
                        last_d   = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (pend_pad_q) begin
                        state_d    = PAD;
                        pend_pad_d = 1'b0;
                        buf_d      = PAD_BLOCK;
                        length_d   = 6'd0;
                        last_d     = 1'b1;
                    end else begin
                        state_d  = FILL;
                        buf_d    = 256'h0;
                        cnt_d    = 6'd0;
                        length_d = 6'd0;
                        last_d   = 1'b0;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            PAD: begin
                if (out_ready) begin
                    state_d  = FILL;
                    buf_d    = 256'h0;
                    cnt_d    = 6'd0;
                    length_d = 6'd0;
                    last_d   = 1'b0;
                end else begin
                    state_d = PAD;
                end
            end
            default: begin
                state_d    = FILL;
                buf_d      = 256'h0;
                cnt_d      = 6'd0;
                pend_pad_d = 1'b0;
                length_d   = 6'd0;
                last_d     = 1'b0;
            end
        endcase
    end

    // State register; asynchronous reset discards any partial block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            cnt_q      <= 6'd0;
            buf_q      <= 256'h0;
            pend_pad_q <= 1'b0;
            length_q   <= 6'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            pend_pad_q <= pend_pad_d;
            length_q   <= length_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_absorb_packer.sv
// Scoreboard bench for absorb_packer: two instances (padding on / off) share
// stimulus; the selected one is fed and drained while expectations come from
// constants or a small packing model.
module tb_absorb_packer;

    typedef struct packed {
        logic [255:0] blk;
        logic [5:0]   len;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;

    logic         a_in_ready, a_out_last, a_out_valid;
    logic [255:0] a_out_block;
    logic [5:0]   a_out_length;
    logic         b_in_ready, b_out_last, b_out_valid;
    logic [255:0] b_out_block;
    logic [5:0]   b_out_length;

    logic         sel;
    logic         cur_in_ready, cur_out_last, cur_out_valid;
    logic [255:0] cur_out_block;
    logic [5:0]   cur_out_length;

    exp_t         exp_q[$];
    logic [7:0]   msg_q[$];
    int           checks = 0;
    int           errors = 0;
    string        tname;
    time          acc_t, valid_t;

    always #5 clk = ~clk;

    absorb_packer #(.BYTES(32), .DOMAIN(8'h1F), .PAD_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(a_in_ready), .out_block(a_out_block),
        .out_length(a_out_length), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(out_ready));

    absorb_packer #(.BYTES(32), .DOMAIN(8'h1F), .PAD_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(b_in_ready), .out_block(b_out_block),
        .out_length(b_out_length), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(out_ready));

    assign cur_in_ready   = sel ? b_in_ready   : a_in_ready;
    assign cur_out_valid  = sel ? b_out_valid  : a_out_valid;
    assign cur_out_block  = sel ? b_out_block  : a_out_block;
    assign cur_out_length = sel ? b_out_length : a_out_length;
    assign cur_out_last   = sel ? b_out_last   : a_out_last;

    task automatic push_exp(input logic [255:0] blk, input logic [5:0] len, input logic last);
        exp_t e;
        e.blk = blk; e.len = len; e.last = last;
        exp_q.push_back(e);
    endtask

    // Reference packing of msg_q into expected blocks.
    task automatic model_push(input bit has_last, input bit pad_en);
        logic [255:0] blk;
        int n;
        blk = 256'h0;
        n = 0;
        for (int i = 0; i < msg_q.size(); i++) begin
            blk[255 - 8*n -: 8] = msg_q[i];
            n++;
            if (n == 32) begin
                if (has_last && i == msg_q.size() - 1) begin
                    push_exp(blk, 6'd32, !pad_en);
                    if (pad_en) push_exp({8'h1F, 240'h0, 8'h80}, 6'd0, 1'b1);
                end else begin
                    push_exp(blk, 6'd32, 1'b0);
                end
                blk = 256'h0;
                n = 0;
            end
        end
        if (n > 0 && has_last) begin
            if (pad_en) begin
                blk[255 - 8*n -: 8] = 8'h1F;
                blk[7:0] = blk[7:0] | 8'h80;
            end
            push_exp(blk, 6'(n), 1'b1);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Presents msg_q byte by byte; called on a negedge.
    task automatic feed(input bit has_last);
        int guard;
        for (int i = 0; i < msg_q.size(); i++) begin
            in_data  = msg_q[i];
            in_valid = 1'b1;
            in_last  = has_last && (i == msg_q.size() - 1);
            guard = 0;
            while (cur_in_ready !== 1'b1 && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) begin
                checks++; errors++;
                $display("FAIL %s feed_timeout byte %0d in_ready got %b exp 1", tname, i, cur_in_ready);
            end
            @(posedge clk);
            acc_t = $time;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Takes n blocks, holding out_ready low for hold cycles on each.
    task automatic drain(input int n, input int hold);
        exp_t e;
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (cur_out_valid !== 1'b1 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (guard >= 500 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s drain_timeout block %0d out_valid got %b exp 1", tname, k, cur_out_valid);
            end else begin
                if (k == 0) valid_t = $time;
                e = exp_q.pop_front();
                checks += 3;
                if (cur_out_block !== e.blk) begin
                    errors++;
                    $display("FAIL %s blk%0d out_block got %h exp %h", tname, k, cur_out_block, e.blk);
                end
                if (cur_out_length !== e.len) begin
                    errors++;
                    $display("FAIL %s blk%0d out_length got %0d exp %0d", tname, k, cur_out_length, e.len);
                end
                if (cur_out_last !== e.last) begin
                    errors++;
                    $display("FAIL %s blk%0d out_last got %b exp %b", tname, k, cur_out_last, e.last);
                end
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    checks++;
                    if (cur_out_valid !== 1'b1 || cur_in_ready !== 1'b0 || cur_out_block !== e.blk ||
                        cur_out_length !== e.len || cur_out_last !== e.last) begin
                        errors++;
                        $display("FAIL %s hold%0d valid/ready/len/last got %b/%b/%0d/%b exp 1/0/%0d/%b",
                                 tname, h, cur_out_valid, cur_in_ready, cur_out_length, cur_out_last, e.len, e.last);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].len == 6'd0) begin
                    checks++;
                    if (cur_out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL %s pad_no_gap out_valid got %b exp 1", tname, cur_out_valid);
                    end
                end
            end
        end
    endtask

    task automatic expect_quiet(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checks++;
            if (cur_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s quiet out_valid got %b exp 0", tname, cur_out_valid);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover_expectations got %0d exp 0", tname, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic run_msg(input bit has_last, input int hold);
        int n;
        n = exp_q.size();
        fork
            feed(has_last);
            drain(n, hold);
        join
    endtask

    task automatic test_reset();
        tname = "reset";
        sel = 1'b0;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            checks++;
            if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1 || cur_out_block !== 256'h0 ||
                cur_out_length !== 6'd0 || cur_out_last !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d valid/ready/len/last got %b/%b/%0d/%b exp 0/1/0/0",
                         s, cur_out_valid, cur_in_ready, cur_out_length, cur_out_last);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_full_with_pad();
        tname = "full_pad";
        sel = 1'b0;
        do_reset();
        msg_q.delete();
        for (int i = 0; i < 32; i++) msg_q.push_back(8'(i));
        push_exp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 6'd32, 1'b0);
        push_exp({8'h1F, 240'h0, 8'h80}, 6'd0, 1'b1);
        run_msg(1'b1, 0);
        expect_quiet(3);
    endtask

    task automatic test_short_pad();
        tname = "short_pad";
        sel = 1'b0;
        do_reset();
        msg_q.delete();
        msg_q.push_back(8'hAA); msg_q.push_back(8'hBB); msg_q.push_back(8'hCC);
        push_exp({8'hAA, 8'hBB, 8'hCC, 8'h1F, 216'h0, 8'h80}, 6'd3, 1'b1);
        run_msg(1'b1, 0);
        checks++;
        if (valid_t - acc_t != 5) begin
            errors++;
            $display("FAIL short_pad latency got %0t exp 5 after accept", valid_t - acc_t);
        end
        expect_quiet(2);
    endtask

    task automatic test_pad_31();
        tname = "pad_31";
        sel = 1'b0;
        do_reset();
        msg_q.delete();
        for (int i = 0; i < 31; i++) msg_q.push_back(8'h11);
        model_push(1'b1, 1'b1);
        run_msg(1'b1, 0);
        expect_quiet(2);
    endtask

    task automatic test_backpressure();
        tname = "backpressure";
        sel = 1'b0;
        do_reset();
        msg_q.delete();
        for (int i = 0; i < 40; i++) msg_q.push_back(8'(8'h40 + i));
        model_push(1'b1, 1'b1);
        run_msg(1'b1, 5);
        expect_quiet(2);
    endtask

    task automatic test_async_reset();
        tname = "async_reset";
        sel = 1'b0;
        do_reset();
        msg_q.delete();
        for (int i = 0; i < 10; i++) msg_q.push_back(8'(8'hE0 + i));
        feed(1'b0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1 || cur_out_block !== 256'h0) begin
            errors++;
            $display("FAIL async_reset immediate valid/ready got %b/%b exp 0/1", cur_out_valid, cur_in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        expect_quiet(3);
        msg_q.delete();
        for (int i = 0; i < 5; i++) msg_q.push_back(8'(8'h50 + i));
        model_push(1'b1, 1'b1);
        run_msg(1'b1, 0);
        expect_quiet(2);
    endtask

    task automatic test_nopad_short();
        tname = "nopad_short";
        sel = 1'b1;
        do_reset();
        msg_q.delete();
        for (int i = 0; i < 5; i++) msg_q.push_back(8'(8'hA0 + i));
        model_push(1'b1, 1'b0);
        run_msg(1'b1, 0);
        expect_quiet(2);
    endtask

    task automatic test_nopad_64();
        tname = "nopad_64";
        sel = 1'b1;
        do_reset();
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(255 - i));
        model_push(1'b0, 1'b0);
        run_msg(1'b0, 1);
        expect_quiet(4);
    endtask

    task automatic test_back_to_back();
        int len;
        tname = "back_to_back";
        sel = 1'b0;
        do_reset();
        for (int m = 0; m < 5; m++) begin
            msg_q.delete();
            len = (m == 0) ? 64 : int'($urandom_range(1, 70));
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            model_push(1'b1, 1'b1);
            run_msg(1'b1, m % 2);
        end
        expect_quiet(2);
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_full_with_pad();
        test_short_pad();
        test_pad_31();
        test_backpressure();
        test_async_reset();
        test_nopad_short();
        test_nopad_64();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/absorb_packer.md
# absorb_packer

Upstream stage of the Haraka-S byte path. It accepts a valid/ready byte stream and packs it into 256-bit sponge-rate blocks. It applies Haraka-S/SHAKE-style padding to the final block and presents each block with a 6-bit message-byte count, which matches the `length` convention of the downstream serializer. Each block is held until the consumer takes it.

## Interface
- `BYTES`, default 32: block size in bytes; fixed at 32 (256-bit rate); other values unsupported.
- `DOMAIN`, default 8'h1F: domain-separation pad byte.
- `PAD_EN`, default 1: 1 = pad final block; 0 = zero-fill only.

- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  this byte is the final message byte; qualified by `in_valid`.
- `in_ready`  out  1  block accepts a byte this cycle.
- `out_block`  out  256  packed block; the first byte of the block sits in [255:248].
- `out_length`  out  6  number of message bytes in `out_block` (0..32); excludes pad bytes.
- `out_last`  out  1  this block is the message's final block.
- `out_valid`  out  1  `out_block`, `out_length` and `out_last` are valid.
- `out_ready`  in  1  consumer takes the block.

## Operation
- Internal state: FSM {FILL, OUT, PAD}, 6-bit byte counter `cnt`, 256-bit buffer `buf`, flag `pend_pad`.
- **FILL** (`in_ready`=1, `out_valid`=0)
  - A byte is accepted when `in_valid` && `in_ready`. It is written to byte index `cnt`, at bits [255-8*cnt -: 8], and `cnt` increments.
  - When an accepted byte makes `cnt`==32 and `in_last`=0: go to OUT with `out_length`=32 and `out_last`=0.
  - When an accepted byte has `in_last`=1, with resulting count n:
    - n<32, PAD_EN=1: byte n = DOMAIN; byte 31 |= 8'h80. For n=31 this gives byte 31 = DOMAIN|8'h80 (8'h9F). `out_last`=1.
    - n<32, PAD_EN=0: bytes n..31 = 0; `out_last`=1.
    - n==32, PAD_EN=1: `out_last`=0 and `pend_pad`=1.
    - n==32, PAD_EN=0: `out_last`=1.
    - In all cases `out_length`=n and the FSM goes to OUT.
- **OUT** (`in_ready`=0, `out_valid`=1)
  - `out_block`, `out_length` and `out_last` are registered and stable until the handshake completes.
  - On `out_ready`:
    - if `pend_pad`: go to PAD and clear `pend_pad`;
    - otherwise: go to FILL, clear `buf`, set `cnt`=0.
- **PAD** (`in_ready`=0, `out_valid`=1)
  - `out_block` = DOMAIN in byte 0, 8'h80 in byte 31, zero elsewhere.
  - `out_length`=0, `out_last`=1.
  - On `out_ready`: go to FILL, clear `buf`, set `cnt`=0.
- `in_last` is ignored unless the byte is accepted. Bytes presented while `in_ready`=0 are not consumed.
- Empty messages are not supported; every message carries at least one byte.
- Reset (asserted low, asynchronous):
  - FSM = FILL; `cnt`, `buf` and `pend_pad` are cleared.
  - Outputs: `out_valid`=0, `out_block`=0, `out_length`=0, `out_last`=0, `in_ready`=1.
  - A partial block in progress is discarded and nothing is emitted.

## Timing
- `in_ready` is a decode of the FSM state, with no combinational path from `out_ready`. All outputs are registered or state decodes.
- Latency: `out_valid` rises on the clock edge that accepts the block-completing byte, so the block is visible in the next cycle.
- The next byte is accepted in the cycle after the `out_valid`&&`out_ready` edge, i.e. there is one idle cycle per block.
- Peak throughput: 32 bytes per 33 cycles, plus one extra block slot when a pad block is needed.
- A pad block follows its data block with no gap once that block is taken.
- When `out_valid`=1 and `out_ready`=0, all outputs hold indefinitely.
- Reset released: `in_ready`=1 on the first cycle after release.

## Test plan
- 32 bytes 8'h00..8'h1F with `in_last` on the 32nd byte, PAD_EN=1:
  - first block 256'h000102…1F, `out_length`=32, `out_last`=0;
  - then 256'h1F00…0080, `out_length`=0, `out_last`=1.
- Bytes AA, BB, CC with `in_last` on CC:
  - one block 256'hAABBCC1F followed by zeros with a final byte 80;
  - `out_length`=3, `out_last`=1, `out_valid` the cycle after CC is accepted.
- 31 bytes of 8'h11 with `in_last`: bytes 0..30 = 11, byte 31 = 9F, `out_length`=31, `out_last`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`:
  - outputs are unchanged, `in_ready`=0, and the input byte is not consumed;
  - after `out_ready` pulses, that byte is accepted on the following cycle and becomes byte 0 of the next block.
- Async reset low mid-cycle after 10 bytes:
  - `out_valid`=0 and `in_ready`=1 immediately, with no block emitted;
  - a following 5-byte message yields `out_length`=5 with a correct pad.
- PAD_EN=0:
  - 5 bytes with `in_last` → zero-filled block, `out_length`=5, `out_last`=1;
  - 64 bytes with no `in_last` → two blocks of `out_length`=32 with `out_last`=0, and no pad block.
